// File: rtl/tinyriscv_pkg.sv
// Shared core definitions: bus widths, hold-flag codes and the pipeline
// sequencer state encoding.
package tinyriscv_pkg;

  localparam int unsigned HoldFlagBusW = 3;
  localparam int unsigned InstAddrBusW = 32;
  localparam int unsigned RegAddrBusW  = 5;

  typedef logic [HoldFlagBusW-1:0] hold_flag_t;
  typedef logic [InstAddrBusW-1:0] inst_addr_t;
  typedef logic [RegAddrBusW-1:0]  reg_addr_t;

  localparam hold_flag_t Hold_None  = 3'd0;
  localparam hold_flag_t Hold_Pc    = 3'd1;
  localparam hold_flag_t Hold_If    = 3'd2;
  localparam hold_flag_t Hold_Id    = 3'd3;
  localparam hold_flag_t Pipe_Clear = 3'd4;

  typedef enum logic [2:0] {
    StRun,
    StFlush,
    StWaitEx,
    StWaitBus,
    StIrq
  } pipe_ctrl_state_e;

  // True when ID needs the GPR that a load currently in EX will write.
  function automatic logic load_use_hazard(
    input logic      ex_is_load,
    input logic      ex_reg_we,
    input reg_addr_t ex_rd,
    input reg_addr_t id_rs1,
    input logic      id_rs1_re,
    input reg_addr_t id_rs2,
    input logic      id_rs2_re
  );
    logic rs1_hit;
    logic rs2_hit;
    rs1_hit = id_rs1_re && (id_rs1 == ex_rd);
    rs2_hit = id_rs2_re && (id_rs2 == ex_rd);
    return ex_is_load && ex_reg_we && (ex_rd != '0) && (rs1_hit || rs2_hit);
  endfunction

endpackage

// File: rtl/gen_en_dff.sv
// Enable-gated D flip-flop bank with asynchronous active-low reset.
//   clk_i    clock
//   rst_ni   async reset, loads ResetVal
//   en_i     load enable
//   d_i      next value
//   q_o      registered value
module gen_en_dff #(
  parameter int unsigned      Width    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= ResetVal;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
//   clk_i    clock
//   rst_ni   async reset to zero
//   inc_i    count one this cycle
//   clear_i  synchronous clear (wins over inc_i)
//   count_o  current count
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: resolves jump flushes, interrupt holds,
// multi-cycle EX stalls, data-bus waits and load-use hazards.
//   clk_i, rst_ni            clock, async active-low reset
//   jump_i, jump_addr_i      EX redirect pulse and target
//   irq_hold_i               interrupt hold request (level)
//   ex_busy_i                multi-cycle EX op in progress (level)
//   bus_req_i, bus_gnt_i     data-bus request / grant
//   ex_is_load_i, ex_reg_we_i, ex_rd_i   EX instruction info
//   id_rs1_i/_re_i, id_rs2_i/_re_i       ID source operands
//   hold_flag_o              pipeline hold code
//   ready_ex_o               EX can accept a new instruction
//   jump_o, jump_addr_o      registered redirect to PC
//   stall_cnt_o, flush_cnt_o saturating performance counters
module pipe_hazard_ctrl
  import tinyriscv_pkg::*;
#(
  parameter int unsigned FlushCycles = 1,
  parameter int unsigned CntWidth    = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    jump_i,
  input  logic [InstAddrBusW-1:0] jump_addr_i,
  input  logic                    irq_hold_i,
  input  logic                    ex_busy_i,
  input  logic                    bus_req_i,
  input  logic                    bus_gnt_i,
  input  logic                    ex_is_load_i,
  input  logic                    ex_reg_we_i,
  input  logic [RegAddrBusW-1:0]  ex_rd_i,
  input  logic [RegAddrBusW-1:0]  id_rs1_i,
  input  logic                    id_rs1_re_i,
  input  logic [RegAddrBusW-1:0]  id_rs2_i,
  input  logic                    id_rs2_re_i,
  output logic [HoldFlagBusW-1:0] hold_flag_o,
  output logic                    ready_ex_o,
  output logic                    jump_o,
  output logic [InstAddrBusW-1:0] jump_addr_o,
  output logic [CntWidth-1:0]     stall_cnt_o,
  output logic [CntWidth-1:0]     flush_cnt_o
);

  localparam logic [2:0] FlushLoad = 3'(FlushCycles);

  pipe_ctrl_state_e state_q, state_d;
  logic [2:0]       state_raw_q;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  hold_flag_t       hold;
  logic             ready;
  logic             bus_wait;
  logic             load_use;

  gen_en_dff #(
    .Width   (3),
    .ResetVal(3'(StRun))
  ) u_state_dff (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (1'b1),
    .d_i   (state_d),
    .q_o   (state_raw_q)
  );
  assign state_q = pipe_ctrl_state_e'(state_raw_q);

  gen_en_dff #(
    .Width   (3),
    .ResetVal(3'd0)
  ) u_flush_cnt_dff (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (1'b1),
    .d_i   (flush_cnt_d),
    .q_o   (flush_cnt_q)
  );

  gen_en_dff #(
    .Width   (1),
    .ResetVal(1'b0)
  ) u_jump_dff (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (1'b1),
    .d_i   (jump_i),
    .q_o   (jump_o)
  );

  gen_en_dff #(
    .Width   (InstAddrBusW),
    .ResetVal('0)
  ) u_jump_addr_dff (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (jump_i),
    .d_i   (jump_addr_i),
    .q_o   (jump_addr_o)
  );

  assign bus_wait = bus_req_i && !bus_gnt_i;
  assign load_use = load_use_hazard(ex_is_load_i, ex_reg_we_i, ex_rd_i, id_rs1_i, id_rs1_re_i,
                                    id_rs2_i, id_rs2_re_i);

  // Wait states are re-derived from the level inputs every cycle, so an
  // interrupted EX/bus wait resumes naturally once a flush completes.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    hold        = Hold_None;
    ready       = 1'b1;
    if (jump_i) begin
      hold        = Pipe_Clear;
      state_d     = StFlush;
      flush_cnt_d = FlushLoad;
    end else if (state_q == StFlush) begin
      hold = Pipe_Clear;
      if (flush_cnt_q <= 3'd1) begin
        state_d     = StRun;
        flush_cnt_d = 3'd0;
      end else begin
        flush_cnt_d = flush_cnt_q - 3'd1;
      end
    end else if (irq_hold_i) begin
      hold    = Hold_Id;
      state_d = StIrq;
    end else if (ex_busy_i) begin
      hold    = Hold_Id;
      ready   = 1'b0;
      state_d = StWaitEx;
    end else if (bus_wait) begin
      hold    = Hold_Id;
      ready   = 1'b0;
      state_d = StWaitBus;
    end else if (load_use) begin
      // The ID/EX bubble clears the hazard next cycle; no state needed.
      hold    = Hold_If;
      state_d = StRun;
    end else begin
      state_d = StRun;
    end
    // Outputs must show idle values for the whole time reset is held.
    if (!rst_ni) begin
      hold  = Hold_None;
      ready = 1'b1;
    end
  end

  assign hold_flag_o = hold;
  assign ready_ex_o  = ready;

  sat_counter #(
    .WIDTH(CntWidth)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (hold != Hold_None),
    .clear_i(1'b0),
    .count_o(stall_cnt_o)
  );

  sat_counter #(
    .WIDTH(CntWidth)
  ) u_flush_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (jump_i),
    .clear_i(1'b0),
    .count_o(flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (FlushCycles = 2, CntWidth = 4).
module tb_pipe_hazard_ctrl;

  localparam logic [3:0] MHold = 4'b0001;
  localparam logic [3:0] MRdy  = 4'b0010;
  localparam logic [3:0] MJmp  = 4'b0100;
  localparam logic [3:0] MCnt  = 4'b1000;
  localparam logic [3:0] MAll  = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        jump;
  logic [31:0] jump_addr;
  logic        irq_hold, ex_busy, bus_req, bus_gnt;
  logic        ex_is_load, ex_reg_we;
  logic [4:0]  ex_rd, id_rs1, id_rs2;
  logic        id_rs1_re, id_rs2_re;
  logic [2:0]  hold_flag;
  logic        ready_ex, jump_out;
  logic [31:0] jump_addr_out;
  logic [3:0]  stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [3:0]  mask;
    logic [2:0]  hold;
    logic        ready;
    logic        jmp;
    logic [31:0] addr;
    logic [3:0]  scnt;
    logic [3:0]  fcnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .FlushCycles(2),
    .CntWidth   (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .jump_i      (jump),
    .jump_addr_i (jump_addr),
    .irq_hold_i  (irq_hold),
    .ex_busy_i   (ex_busy),
    .bus_req_i   (bus_req),
    .bus_gnt_i   (bus_gnt),
    .ex_is_load_i(ex_is_load),
    .ex_reg_we_i (ex_reg_we),
    .ex_rd_i     (ex_rd),
    .id_rs1_i    (id_rs1),
    .id_rs1_re_i (id_rs1_re),
    .id_rs2_i    (id_rs2),
    .id_rs2_re_i (id_rs2_re),
    .hold_flag_o (hold_flag),
    .ready_ex_o  (ready_ex),
    .jump_o      (jump_out),
    .jump_addr_o (jump_addr_out),
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_cyc(input string tag, input logic [3:0] mask, input logic [2:0] hold,
                            input logic ready, input logic jmp, input logic [31:0] addr,
                            input logic [3:0] scnt, input logic [3:0] fcnt);
    exp_t x;
    x.tag = tag; x.mask = mask; x.hold = hold; x.ready = ready;
    x.jmp = jmp; x.addr = addr; x.scnt = scnt; x.fcnt = fcnt;
    sb_q.push_back(x);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    jump = 0; jump_addr = '0; irq_hold = 0; ex_busy = 0; bus_req = 0; bus_gnt = 0;
    ex_is_load = 0; ex_reg_we = 0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
    id_rs1_re = 0; id_rs2_re = 0;
  endtask

  task automatic reset_dut();
    rst_ni = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  // Monitor: compares one scoreboard entry per cycle, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.mask[0]) cmp($sformatf("%s.hold", e.tag), 32'(hold_flag), 32'(e.hold));
        if (e.mask[1]) cmp($sformatf("%s.ready", e.tag), 32'(ready_ex), 32'(e.ready));
        if (e.mask[2]) begin
          cmp($sformatf("%s.jump", e.tag), 32'(jump_out), 32'(e.jmp));
          if (e.jmp) cmp($sformatf("%s.jaddr", e.tag), jump_addr_out, e.addr);
        end
        if (e.mask[3]) begin
          cmp($sformatf("%s.stall_cnt", e.tag), 32'(stall_cnt), 32'(e.scnt));
          cmp($sformatf("%s.flush_cnt", e.tag), 32'(flush_cnt), 32'(e.fcnt));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    reset_dut();

    // Reset while stalled on EX busy.
    ex_busy = 1;
    for (int i = 0; i < 3; i++) begin
      expect_cyc("exwait_pre_rst", MHold | MRdy | MCnt, 3'd3, 1'b0, 1'b0, 0, 4'(i), 4'd0);
      next_cyc();
    end
    rst_ni = 1'b0;
    expect_cyc("mid_rst", MAll, 3'd0, 1'b1, 1'b0, 0, 4'd0, 4'd0);
    next_cyc();

    // Jump with two flush cycles.
    reset_dut();
    jump = 1; jump_addr = 32'h100;
    expect_cyc("jmp_c0", MHold | MJmp | MCnt, 3'd4, 1'b1, 1'b0, 0, 4'd0, 4'd0);
    next_cyc();
    jump = 0; jump_addr = '0;
    expect_cyc("jmp_c1", MHold | MJmp | MCnt, 3'd4, 1'b1, 1'b1, 32'h100, 4'd1, 4'd1);
    next_cyc();
    expect_cyc("jmp_c2", MHold | MJmp | MCnt, 3'd4, 1'b1, 1'b0, 0, 4'd2, 4'd1);
    next_cyc();
    expect_cyc("jmp_c3", MAll, 3'd0, 1'b1, 1'b0, 0, 4'd3, 4'd1);
    next_cyc();

    // EX busy for four cycles.
    reset_dut();
    ex_busy = 1;
    for (int i = 0; i < 4; i++) begin
      expect_cyc("exbusy", MHold | MRdy | MCnt, 3'd3, 1'b0, 1'b0, 0, 4'(i), 4'd0);
      next_cyc();
    end
    ex_busy = 0;
    expect_cyc("exbusy_done", MAll, 3'd0, 1'b1, 1'b0, 0, 4'd4, 4'd0);
    next_cyc();

    // Load-use hazards.
    reset_dut();
    ex_is_load = 1; ex_reg_we = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_re = 1;
    expect_cyc("lu_rs2", MHold | MRdy | MCnt, 3'd2, 1'b1, 1'b0, 0, 4'd0, 4'd0);
    next_cyc();
    clear_inputs();
    expect_cyc("lu_bubble", MHold | MRdy | MCnt, 3'd0, 1'b1, 1'b0, 0, 4'd1, 4'd0);
    next_cyc();
    ex_is_load = 1; ex_reg_we = 1; ex_rd = 5'd0; id_rs2 = 5'd0; id_rs2_re = 1;
    expect_cyc("lu_x0", MHold | MCnt, 3'd0, 1'b1, 1'b0, 0, 4'd1, 4'd0);
    next_cyc();
    clear_inputs();
    ex_is_load = 1; ex_reg_we = 1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_re = 1;
    expect_cyc("lu_rs1", MHold | MCnt, 3'd2, 1'b1, 1'b0, 0, 4'd1, 4'd0);
    next_cyc();
    id_rs1_re = 0;
    expect_cyc("lu_no_re", MHold | MCnt, 3'd0, 1'b1, 1'b0, 0, 4'd2, 4'd0);
    next_cyc();
    ex_is_load = 0; id_rs1_re = 1;
    expect_cyc("lu_not_load", MHold | MCnt, 3'd0, 1'b1, 1'b0, 0, 4'd2, 4'd0);
    next_cyc();

    // Bus wait interrupted by a jump, resumed afterwards.
    reset_dut();
    bus_req = 1; bus_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      expect_cyc("bus_wait", MHold | MRdy | MCnt, 3'd3, 1'b0, 1'b0, 0, 4'(i), 4'd0);
      next_cyc();
    end
    jump = 1; jump_addr = 32'h200;
    expect_cyc("bus_jmp", MHold | MJmp | MCnt, 3'd4, 1'b1, 1'b0, 0, 4'd3, 4'd0);
    next_cyc();
    jump = 0;
    expect_cyc("bus_fl1", MHold | MJmp | MCnt, 3'd4, 1'b1, 1'b1, 32'h200, 4'd4, 4'd1);
    next_cyc();
    expect_cyc("bus_fl2", MHold | MJmp, 3'd4, 1'b1, 1'b0, 0, 4'd5, 4'd1);
    next_cyc();
    expect_cyc("bus_rewait", MHold | MRdy | MCnt, 3'd3, 1'b0, 1'b0, 0, 4'd6, 4'd1);
    next_cyc();
    bus_gnt = 1;
    expect_cyc("bus_gnt", MAll, 3'd0, 1'b1, 1'b0, 0, 4'd7, 4'd1);
    next_cyc();
    expect_cyc("bus_req_gnt", MHold | MRdy | MCnt, 3'd0, 1'b1, 1'b0, 0, 4'd7, 4'd1);
    next_cyc();

    // Jump arriving mid-flush restarts the flush.
    reset_dut();
    jump = 1; jump_addr = 32'h10;
    expect_cyc("rejmp_c0", MHold | MCnt, 3'd4, 1'b1, 1'b0, 0, 4'd0, 4'd0);
    next_cyc();
    jump_addr = 32'h20;
    expect_cyc("rejmp_c1", MHold | MJmp | MCnt, 3'd4, 1'b1, 1'b1, 32'h10, 4'd1, 4'd1);
    next_cyc();
    jump = 0;
    expect_cyc("rejmp_c2", MHold | MJmp | MCnt, 3'd4, 1'b1, 1'b1, 32'h20, 4'd2, 4'd2);
    next_cyc();
    expect_cyc("rejmp_c3", MHold | MJmp | MCnt, 3'd4, 1'b1, 1'b0, 0, 4'd3, 4'd2);
    next_cyc();
    expect_cyc("rejmp_c4", MAll, 3'd0, 1'b1, 1'b0, 0, 4'd4, 4'd2);
    next_cyc();

    // IRQ hold long enough to saturate the 4-bit stall counter.
    reset_dut();
    irq_hold = 1;
    for (int i = 0; i < 20; i++) begin
      expect_cyc("irq", MHold | MRdy | MCnt, 3'd3, 1'b1, 1'b0, 0, 4'((i > 15) ? 15 : i), 4'd0);
      next_cyc();
    end
    irq_hold = 0;
    expect_cyc("irq_off", MHold | MRdy | MCnt, 3'd0, 1'b1, 1'b0, 0, 4'd15, 4'd0);
    next_cyc();
    irq_hold = 1; ex_busy = 1;
    expect_cyc("irq_over_busy", MHold | MRdy | MCnt, 3'd3, 1'b1, 1'b0, 0, 4'd15, 4'd0);
    next_cyc();
    ex_busy = 0; jump = 1; jump_addr = 32'h44;
    expect_cyc("jmp_over_irq", MHold, 3'd4, 1'b1, 1'b0, 0, 4'd15, 4'd0);
    next_cyc();
    jump = 0; irq_hold = 0;
    expect_cyc("jmp_irq_f1", MHold | MJmp | MCnt, 3'd4, 1'b1, 1'b1, 32'h44, 4'd15, 4'd1);
    next_cyc();
    expect_cyc("jmp_irq_f2", MHold, 3'd4, 1'b1, 1'b0, 0, 4'd15, 4'd1);
    next_cyc();
    expect_cyc("jmp_irq_end", MHold | MRdy | MCnt, 3'd0, 1'b1, 1'b0, 0, 4'd15, 4'd1);
    next_cyc();

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) next_cyc();
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
